uart_prog_loader: RTL

//  SoC-side boot loader that sits downstream of the UART programming bench.
//  It receives 8N1 serial bytes on rx_serial and packs each group of 4 bytes into a 32-bit word.

---
 rtl/uart_prog_loader_if.sv | 24 ++
 rtl/uart_prog_loader.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/uart_prog_loader_if.sv
// Loader-side bundle: host controls (prog_en, rx_serial) in, imem write port and status out.
interface uart_prog_loader_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  prog_en;
  logic                  rx_serial;
  logic                  prog_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;
  logic                  prog_done;
  logic                  frame_err;
  logic                  overflow;

  modport master (
    input  prog_en, rx_serial,
    output prog_ready, imem_we, imem_addr, imem_wdata, prog_done, frame_err, overflow
  );

  modport slave (
    output prog_en, rx_serial,
    input  prog_ready, imem_we, imem_addr, imem_wdata, prog_done, frame_err, overflow
  );
endinterface

// File: rtl/uart_prog_loader.sv
// UART 8N1 boot loader: packs big-endian byte quads into words and writes them to
// consecutive imem addresses until the terminator word or the end of memory.
module uart_prog_loader #(
  parameter int          CLKS_PER_BIT = 348,
  parameter int          ADDR_WIDTH   = 12,
  parameter logic [31:0] TERM_WORD    = 32'h00000FFF
) (
  input logic               clk,
  input logic               rst,
  uart_prog_loader_if.master bus
);

  localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} top_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  top_state_t            state;
  rx_state_t             rx_state;
  logic                  rx_sync_p0, rx_sync_p1;
  logic [CNT_W-1:0]      clk_cnt;
  logic [2:0]            bit_idx;
  logic [7:0]            rx_byte;
  logic [31:0]           word;
  logic [31:0]           word_next;
  logic [1:0]            byte_cnt;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;
  logic                  frame_err;
  logic                  overflow;

  assign word_next = {word[23:0], rx_byte};

  // Stage p0/p1: two-flop synchroniser, idle-high so reset looks like a quiet line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
    end else begin
      rx_sync_p0 <= bus.rx_serial;
      rx_sync_p1 <= rx_sync_p0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rx_state   <= RX_IDLE;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      rx_byte    <= '0;
      word       <= '0;
      byte_cnt   <= '0;
      addr       <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        IDLE: begin
          rx_state <= RX_IDLE;
          if (bus.prog_en) begin
            state     <= LOAD;
            addr      <= '0;
            byte_cnt  <= '0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
          end
        end
        DONE: begin
          rx_state <= RX_IDLE;
          if (!bus.prog_en) state <= IDLE;
        end
        LOAD: begin
          // Abort has priority over a byte completing in the same cycle
          if (!bus.prog_en) begin
            state    <= IDLE;
            rx_state <= RX_IDLE;
          end else begin
            case (rx_state)
              RX_IDLE: begin
                clk_cnt <= '0;
                if (!rx_sync_p1) rx_state <= RX_START;
              end
              RX_START: begin
                if (clk_cnt == HALF_LAST) begin
                  clk_cnt  <= '0;
                  bit_idx  <= '0;
                  rx_state <= rx_sync_p1 ? RX_IDLE : RX_DATA;
                end else begin
                  clk_cnt <= clk_cnt + 1'b1;
                end
              end
              RX_DATA: begin
                if (clk_cnt == BIT_LAST) begin
                  clk_cnt <= '0;
                  rx_byte <= {rx_sync_p1, rx_byte[7:1]};
                  if (bit_idx == 3'd7) rx_state <= RX_STOP;
                  else                 bit_idx  <= bit_idx + 1'b1;
                end else begin
                  clk_cnt <= clk_cnt + 1'b1;
                end
              end
              RX_STOP: begin
                if (clk_cnt == BIT_LAST) begin
                  clk_cnt  <= '0;
                  rx_state <= RX_IDLE;
                  if (!rx_sync_p1) begin
                    frame_err <= 1'b1;
                  end else begin
                    word     <= word_next;
                    byte_cnt <= byte_cnt + 1'b1;
                    if (byte_cnt == 2'd3) begin
                      if (word_next == TERM_WORD) begin
                        state <= DONE;
                      end else begin
                        imem_we    <= 1'b1;
                        imem_addr  <= addr;
                        imem_wdata <= word_next;
                        addr       <= addr + 1'b1;
                        if (addr == '1) begin
                          state    <= DONE;
                          overflow <= 1'b1;
                        end
                      end
                    end
                  end
                end else begin
                  clk_cnt <= clk_cnt + 1'b1;
                end
              end
              default: rx_state <= RX_IDLE;
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.prog_ready = (state == LOAD);
  assign bus.prog_done  = (state == DONE);
  assign bus.imem_we    = imem_we;
  assign bus.imem_addr  = imem_addr;
  assign bus.imem_wdata = imem_wdata;
  assign bus.frame_err  = frame_err;
  assign bus.overflow   = overflow;

endmodule
